// File: rtl/ghist_hist_ctrl.sv
// Speculative global-history controller: tracks the live history, snapshots it per fetch
// packet into an external 1R1W memory and rebuilds it from a snapshot on a redirect.
module ghist_hist_ctrl #(
  parameter int unsigned ENTRIES  = 40,
  parameter int unsigned HIST_LEN = 72,
  parameter int unsigned PTR_W    = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic                enq_has_br,
  input  logic                enq_taken,
  output logic [PTR_W-1:0]    enq_idx,
  input  logic                deq_valid,
  output logic [PTR_W-1:0]    deq_idx,
  input  logic                redirect_valid,
  input  logic [PTR_W-1:0]    redirect_idx,
  input  logic                redirect_has_br,
  input  logic                redirect_taken,
  output logic [HIST_LEN-1:0] spec_ghist,
  output logic                recovering,
  output logic [PTR_W-1:0]    count,
  output logic                mem_w_en,
  output logic [PTR_W-1:0]    mem_w_addr,
  output logic [HIST_LEN-1:0] mem_w_data,
  output logic                mem_r_en,
  output logic [PTR_W-1:0]    mem_r_addr,
  input  logic [HIST_LEN-1:0] mem_r_data
);

  typedef enum logic [1:0] {StIdle, StRd, StWb} state_e;

  state_e              state_q, state_d;
  logic [HIST_LEN-1:0] ghist_q, ghist_d;
  logic [PTR_W-1:0]    enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0]    deq_ptr_q, deq_ptr_d;
  logic [PTR_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    ridx_q, ridx_d;
  logic                rbr_q, rbr_d;
  logic                rtk_q, rtk_d;

  logic                enq_fire;
  logic                deq_fire;
  logic [PTR_W-1:0]    deq_ptr_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Distance a - b modulo ENTRIES; the 6-bit wrap plus ENTRIES lands back in range.
  function automatic logic [PTR_W-1:0] ptr_dist(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
    return (a >= b) ? a - b : a - b + PTR_W'(ENTRIES);
  endfunction

  assign enq_ready = ~reset & (state_q == StIdle) & (count_q < PTR_W'(ENTRIES)) &
                     ~redirect_valid;
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & (count_q != '0);
  assign deq_ptr_nxt = deq_fire ? ptr_inc(deq_ptr_q) : deq_ptr_q;

  always_comb begin
    state_d   = state_q;
    ghist_d   = ghist_q;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_nxt;
    count_d   = count_q;
    ridx_d    = ridx_q;
    rbr_d     = rbr_q;
    rtk_d     = rtk_q;
    if (redirect_valid) begin
      // Squash everything younger than the redirected entry and restart recovery.
      state_d   = StRd;
      ridx_d    = redirect_idx;
      rbr_d     = redirect_has_br;
      rtk_d     = redirect_taken;
      enq_ptr_d = ptr_inc(redirect_idx);
      count_d   = ptr_dist(redirect_idx, deq_ptr_nxt) + PTR_W'(1);
    end else begin
      if (enq_fire) begin
        ghist_d   = enq_has_br ? {ghist_q[HIST_LEN-2:0], enq_taken} : ghist_q;
        enq_ptr_d = ptr_inc(enq_ptr_q);
      end
      if (enq_fire && !deq_fire) begin
        count_d = count_q + PTR_W'(1);
      end else if (deq_fire && !enq_fire) begin
        count_d = count_q - PTR_W'(1);
      end
      unique case (state_q)
        StRd: state_d = StWb;
        StWb: begin
          ghist_d = rbr_q ? {mem_r_data[HIST_LEN-2:0], rtk_q} : mem_r_data;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      ghist_q   <= '0;
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
      ridx_q    <= '0;
      rbr_q     <= 1'b0;
      rtk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ghist_q   <= ghist_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
      ridx_q    <= ridx_d;
      rbr_q     <= rbr_d;
      rtk_q     <= rtk_d;
    end
  end

  assign enq_idx    = enq_ptr_q;
  assign deq_idx    = deq_ptr_q;
  assign count      = count_q;
  assign spec_ghist = ghist_q;
  assign recovering = ~reset & (state_q != StIdle);
  assign mem_w_en   = enq_fire;
  assign mem_w_addr = enq_ptr_q;
  assign mem_w_data = ghist_q;
  assign mem_r_en   = ~reset & (state_q == StRd);
  assign mem_r_addr = ridx_q;

endmodule

// File: tb/tb_ghist_hist_ctrl.sv
// Bench for ghist_hist_ctrl: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a queue-level model of the history controller.
module tb_ghist_hist_ctrl;
  localparam int ENTRIES = 40;
  localparam int HL      = 72;
  localparam int PW      = 6;
  typedef logic [HL-1:0] w_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid, enq_ready, enq_has_br, enq_taken;
  logic [PW-1:0] enq_idx, deq_idx, count;
  logic          deq_valid;
  logic          redirect_valid, redirect_has_br, redirect_taken;
  logic [PW-1:0] redirect_idx;
  logic [HL-1:0] spec_ghist;
  logic          recovering;
  logic          mem_w_en, mem_r_en;
  logic [PW-1:0] mem_w_addr, mem_r_addr;
  logic [HL-1:0] mem_w_data, mem_r_data;

  ghist_hist_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_has_br     (enq_has_br),
    .enq_taken      (enq_taken),
    .enq_idx        (enq_idx),
    .deq_valid      (deq_valid),
    .deq_idx        (deq_idx),
    .redirect_valid (redirect_valid),
    .redirect_idx   (redirect_idx),
    .redirect_has_br(redirect_has_br),
    .redirect_taken (redirect_taken),
    .spec_ghist     (spec_ghist),
    .recovering     (recovering),
    .count          (count),
    .mem_w_en       (mem_w_en),
    .mem_w_addr     (mem_w_addr),
    .mem_w_data     (mem_w_data),
    .mem_r_en       (mem_r_en),
    .mem_r_addr     (mem_r_addr),
    .mem_r_data     (mem_r_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input w_t got, input w_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // External memory; one entry can be overridden so a known snapshot is read back.
  logic [HL-1:0] mem [ENTRIES];
  logic          ovr_en = 1'b0;
  logic [PW-1:0] ovr_idx = '0;
  logic [HL-1:0] ovr_data = '0;

  always @(posedge clock) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= (ovr_en && mem_r_addr == ovr_idx) ? ovr_data : mem[mem_r_addr];
  end

  // Behavioural model: live entries are the ring [m_deq, m_deq + m_cnt) modulo 40, and a
  // redirect leaves two cycles of recovery, the last of which restores the history.
  logic [HL-1:0] m_spec;
  logic [HL-1:0] m_snap [ENTRIES];
  logic [HL-1:0] m_rd;
  int            m_enq, m_deq, m_cnt, rec_left, m_ridx, nd;
  bit            m_rbr, m_rtk, dfire, efire;
  bit            model_ok = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_spec = '0; m_enq = 0; m_deq = 0; m_cnt = 0; rec_left = 0;
      model_ok = 1;
    end else if (model_ok) begin
      dfire = deq_valid && m_cnt > 0;
      efire = enq_valid && rec_left == 0 && m_cnt < ENTRIES && !redirect_valid;
      nd = dfire ? (m_deq + 1) % ENTRIES : m_deq;
      if (redirect_valid) begin
        m_ridx = int'(redirect_idx);
        m_rbr = redirect_has_br;
        m_rtk = redirect_taken;
        rec_left = 2;
        m_enq = (m_ridx + 1) % ENTRIES;
        m_cnt = ((m_ridx - nd + ENTRIES) % ENTRIES) + 1;
      end else begin
        if (efire) begin
          m_snap[m_enq] = m_spec;
          if (enq_has_br) m_spec = {m_spec[HL-2:0], enq_taken};
          m_enq = (m_enq + 1) % ENTRIES;
        end
        m_cnt = m_cnt + (efire ? 1 : 0) - (dfire ? 1 : 0);
        if (rec_left == 1) begin
          m_rd = (ovr_en && m_ridx == int'(ovr_idx)) ? ovr_data : m_snap[m_ridx];
          m_spec = m_rbr ? {m_rd[HL-2:0], m_rtk} : m_rd;
        end
        if (rec_left > 0) rec_left--;
      end
      m_deq = nd;
    end
  end

  bit e_rdy, e_wen, e_ren;
  always @(negedge clock) begin
    if (model_ok) begin
      e_rdy = !reset && rec_left == 0 && m_cnt < ENTRIES && !redirect_valid;
      e_wen = enq_valid && e_rdy;
      e_ren = !reset && rec_left == 2;
      chk("enq_ready", w_t'(enq_ready), w_t'(e_rdy));
      chk("enq_idx", w_t'(enq_idx), w_t'(m_enq));
      chk("deq_idx", w_t'(deq_idx), w_t'(m_deq));
      chk("count", w_t'(count), w_t'(m_cnt));
      chk("spec_ghist", spec_ghist, m_spec);
      chk("recovering", w_t'(recovering), w_t'(!reset && rec_left > 0));
      chk("mem_w_en", w_t'(mem_w_en), w_t'(e_wen));
      if (e_wen) begin
        chk("mem_w_addr", w_t'(mem_w_addr), w_t'(m_enq));
        chk("mem_w_data", mem_w_data, m_spec);
      end
      chk("mem_r_en", w_t'(mem_r_en), w_t'(e_ren));
      if (e_ren) chk("mem_r_addr", w_t'(mem_r_addr), w_t'(m_ridx));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input bit ev, input bit hb, input bit tk, input bit dv, input bit rv,
                        input int ri, input bit rhb, input bit rtk);
    enq_valid = ev; enq_has_br = hb; enq_taken = tk; deq_valid = dv;
    redirect_valid = rv; redirect_idx = PW'(ri); redirect_has_br = rhb; redirect_taken = rtk;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic enq_n(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1, 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0);
      tick();
    end
    idle_in();
  endtask

  task automatic rand_step();
    int  r;
    bit  rv, dv;
    rv = (m_cnt > 0) && ($urandom_range(0, 7) == 0);
    r  = rv ? int'($urandom_range(0, m_cnt - 1)) : 0;
    dv = ($urandom_range(0, 2) == 0);
    if (rv && r == 0) dv = 0;
    if (!rv && rec_left > 0 && m_deq == m_ridx) dv = 0;
    set_in($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), dv, rv,
           (m_deq + r) % ENTRIES, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    enq_valid = 1'b1;
    #2;
    chk("rst_enq_ready", w_t'(enq_ready), '0);
    chk("rst_mem_w_en", w_t'(mem_w_en), '0);
    chk("rst_mem_r_en", w_t'(mem_r_en), '0);
    do_reset();
    chk("rst_count", w_t'(count), '0);
    chk("rst_spec", spec_ghist, '0);
    chk("rst_enq_idx", w_t'(enq_idx), '0);

    // Three packets: (br,taken) = (1,1), (0,-), (1,0).
    set_in(1, 1, 1, 0, 0, 0, 0, 0); #1;
    chk("w0_addr", w_t'(mem_w_addr), w_t'(0)); chk("w0_data", mem_w_data, w_t'(0)); tick();
    set_in(1, 0, 1, 0, 0, 0, 0, 0); #1;
    chk("w1_addr", w_t'(mem_w_addr), w_t'(1)); chk("w1_data", mem_w_data, w_t'(1)); tick();
    set_in(1, 1, 0, 0, 0, 0, 0, 0); #1;
    chk("w2_addr", w_t'(mem_w_addr), w_t'(2)); chk("w2_data", mem_w_data, w_t'(1)); tick();
    idle_in(); #1;
    chk("three_spec", spec_ghist, w_t'(2));
    chk("three_count", w_t'(count), w_t'(3));

    // Fill all 40 entries.
    do_reset();
    enq_n(40);
    enq_valid = 1'b1; #1;
    chk("full_ready", w_t'(enq_ready), '0);
    chk("full_count", w_t'(count), w_t'(40));
    chk("full_enq_idx", w_t'(enq_idx), '0);
    set_in(1, 0, 0, 1, 0, 0, 0, 0); tick();
    set_in(1, 1, 1, 0, 0, 0, 0, 0); #1;
    chk("unfull_ready", w_t'(enq_ready), w_t'(1));
    chk("unfull_waddr", w_t'(mem_w_addr), '0);
    tick();
    idle_in();

    // Redirect to entry 4 whose snapshot reads back as 0xA5.
    do_reset();
    enq_n(10);
    ovr_en = 1'b1; ovr_idx = PW'(4); ovr_data = w_t'(8'hA5);
    set_in(0, 0, 0, 0, 1, 4, 1, 1); tick();
    idle_in(); #1;
    chk("rd_en", w_t'(mem_r_en), w_t'(1));
    chk("rd_addr", w_t'(mem_r_addr), w_t'(4));
    chk("rd_enq_idx", w_t'(enq_idx), w_t'(5));
    chk("rd_count", w_t'(count), w_t'(5));
    tick();
    enq_valid = 1'b1; #1;
    chk("wb_ready", w_t'(enq_ready), '0);
    chk("wb_recovering", w_t'(recovering), w_t'(1));
    tick(); #1;
    chk("restored_spec", spec_ghist, w_t'(12'h14B));
    chk("post_rec_wen", w_t'(mem_w_en), w_t'(1));
    tick();
    idle_in();
    ovr_en = 1'b0;

    // Redirect to 2, then to 1 while the first read is in flight.
    set_in(0, 0, 0, 0, 1, 2, 1, 0); tick();
    set_in(0, 0, 0, 0, 1, 1, 1, 0); #1;
    chk("rr_first_addr", w_t'(mem_r_addr), w_t'(2));
    tick();
    idle_in(); #1;
    chk("rr_second_en", w_t'(mem_r_en), w_t'(1));
    chk("rr_second_addr", w_t'(mem_r_addr), w_t'(1));
    tick(); tick(); #1;
    chk("rr_enq_idx", w_t'(enq_idx), w_t'(2));

    // Enqueue, dequeue and redirect all offered together.
    set_in(1, 1, 1, 1, 1, 1, 0, 0); #1;
    chk("collide_wen", w_t'(mem_w_en), '0);
    chk("collide_ready", w_t'(enq_ready), '0);
    tick();
    idle_in(); #1;
    chk("collide_deq_idx", w_t'(deq_idx), w_t'(1));
    chk("collide_count", w_t'(count), w_t'(1));
    tick(); tick();

    // Wrapped ring: deq at 38, enq at 3, redirect to 1.
    do_reset();
    enq_n(38);
    for (int i = 0; i < 38; i++) begin
      set_in(0, 0, 0, 1, 0, 0, 0, 0); tick();
    end
    enq_n(5); #1;
    chk("wrap_deq_idx", w_t'(deq_idx), w_t'(38));
    chk("wrap_enq_idx0", w_t'(enq_idx), w_t'(3));
    set_in(0, 0, 0, 0, 1, 1, 0, 1); tick();
    idle_in(); #1;
    chk("wrap_count", w_t'(count), w_t'(4));
    chk("wrap_enq_idx", w_t'(enq_idx), w_t'(2));
    tick(); tick();

    // Dequeue on an empty queue.
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 0, 0); tick();
    idle_in(); #1;
    chk("empty_count", w_t'(count), '0);
    chk("empty_deq_idx", w_t'(deq_idx), '0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      rand_step();
      tick();
    end
    idle_in();
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ghist_hist_ctrl.md
Name: ghist_hist_ctrl

Overview:
- Speculative global-history controller for the fetch target queue.
- Holds the live 72-bit speculative global history that drives the predictors.
- Writes one history snapshot per enqueued fetch packet into the 40-entry ghist memory (1R1W, 72 bits wide, read data valid one cycle after read enable).
- On a branch redirect, reads back the snapshot for the mispredicted packet and rebuilds the speculative history from it.

Parameters:
- ENTRIES, 40, number of queue entries (memory depth).
- HIST_LEN, 72, global history length in bits (memory width).
- PTR_W, 6, pointer and index width; ceil(log2(ENTRIES)).

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  fetch packet offered.
- enq_ready  out  1  packet accepted this cycle when enq_valid is also high.
- enq_has_br  in  1  packet contains a conditional branch.
- enq_taken  in  1  predicted direction of that branch.
- enq_idx  out  PTR_W  queue index assigned to the offered packet (the enq pointer).
- deq_valid  in  1  commit frees the oldest entry.
- deq_idx  out  PTR_W  index of the oldest live entry.
- redirect_valid  in  1  mispredict or redirect for a live entry.
- redirect_idx  in  PTR_W  entry being redirected.
- redirect_has_br  in  1  the redirected packet has a resolved conditional branch.
- redirect_taken  in  1  resolved direction.
- spec_ghist  out  HIST_LEN  current speculative history; bit 0 is the newest outcome.
- recovering  out  1  high while the history is being rebuilt.
- count  out  PTR_W  number of live entries, 0..40.
- mem_w_en  out  1  memory write enable.
- mem_w_addr  out  PTR_W  memory write address.
- mem_w_data  out  HIST_LEN  memory write data.
- mem_r_en  out  1  memory read enable.
- mem_r_addr  out  PTR_W  memory read address.
- mem_r_data  in  HIST_LEN  memory read data, valid the cycle after mem_r_en.

Behaviour:
- Reset (synchronous):
  - spec_ghist=0, enq_ptr=0, deq_ptr=0, count=0, state=IDLE.
  - During reset: mem_w_en=0, mem_r_en=0, recovering=0, enq_ready=0.
- States:
  - IDLE: normal operation.
  - RD: read issued for the redirected entry.
  - WB: read data returns; history is restored.
- enq_ready = (state==IDLE) & (count<ENTRIES) & ~redirect_valid. Combinational; does not depend on enq_valid.
- Enqueue fire (enq_valid & enq_ready), same cycle:
  - mem_w_en=1, mem_w_addr=enq_ptr, mem_w_data=spec_ghist. The snapshot is the history before this packet.
  - Next spec_ghist = enq_has_br ? {spec_ghist[HIST_LEN-2:0], enq_taken} : spec_ghist.
  - enq_ptr advances by 1, wrapping 39 -> 0.
- Dequeue (deq_valid & count>0):
  - deq_ptr advances by 1, wrapping 39 -> 0.
  - deq_valid while count==0 is ignored.
- Count:
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Otherwise count moves by +1 or -1.
- Redirect accepted in any state:
  - Next state RD; latch redirect_idx, redirect_has_br, redirect_taken.
  - enq_ptr <= (redirect_idx+1) mod 40; younger entries are squashed.
  - count <= ((redirect_idx - deq_ptr') mod 40) + 1, where deq_ptr' is deq_ptr after any same-cycle dequeue.
  - No enqueue in a redirect cycle.
- RD (one cycle): mem_r_en=1, mem_r_addr=latched idx, recovering=1; next state WB.
- WB (one cycle): recovering=1.
  - spec_ghist <= has_br ? {mem_r_data[HIST_LEN-2:0], taken} : mem_r_data.
  - Next state IDLE.
- Redirect during RD or WB restarts at RD with the new index; the latest redirect wins and the in-flight read data is discarded.
- Redirect to enq latency: an enqueue may fire at the earliest 3 cycles after the redirect cycle (redirect cycle, RD, WB, then IDLE).
- mem_w_en is never asserted in RD or WB, so no same-address read/write collision can occur.
- Wrap-around arithmetic is explicit mod 40, never mod 64; indices 40..63 are never produced.
- Preconditions (bench asserts; RTL behaviour undefined if violated):
  - redirect_idx refers to a live entry.
  - A dequeue never frees the entry under recovery.

Test Plan:
- Reset, then 3 enqueues with (has_br, taken) = (1,1), (0,x), (1,0):
  - mem writes at idx 0, 1, 2 with data 0x0, 0x1, 0x1.
  - Final spec_ghist = 0x2; count = 3.
- Enqueue 40 packets with no dequeue:
  - enq_ready drops after the 40th; count = 40; enq_idx wraps to 0.
  - One deq_valid restores enq_ready the next cycle.
  - The next enqueue writes idx 0.
- With entries 0..9 live, redirect_idx=4, has_br=1, taken=1, mem_r_data=0xA5:
  - RD reads addr 4; after WB spec_ghist = 0x14B.
  - enq_idx = 5, count = 5; first enqueue fires 3 cycles after the redirect.
- Redirect to idx 2, then redirect to idx 1 during the RD cycle:
  - A second read is issued at addr 1; the idx-2 data is discarded.
  - enq_idx = 2 at the end.
- enq_valid and redirect_valid in the same cycle:
  - No write occurs and the enqueue is not accepted.
  - deq_valid in that cycle still advances deq_idx, and count reflects it.
- Wrap case, deq_ptr=38, enq_ptr=3, redirect_idx=1:
  - Required: count = 4, enq_idx = 2.
- deq_valid while empty: count stays 0; deq_idx unchanged.
